fetch_unit: RTL and testbench

Instruction fetch sequencer for the 16-bit CPU. It owns the program counter and runs a request/acknowledge handshake with instruction memory. It delivers each fetched word, with its address, to the instruction register stage. It sits directly upstream of the instruction register: INSTR and INSTR_VALID drive that register's data and load qualification.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory handshake and the instruction-register
// delivery signals seen by the fetch sequencer.
interface fetch_unit_if;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic        STALL;
  logic        JMP;
  logic [15:0] JMP_ADDR;
  logic [15:0] INSTR;
  logic [15:0] INSTR_PC;
  logic        INSTR_VALID;

  modport master (
    output MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    input  MEM_ACK, MEM_DATA, STALL, JMP, JMP_ADDR
  );

  modport slave (
    input  MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    output MEM_ACK, MEM_DATA, STALL, JMP, JMP_ADDR
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, handshakes with instruction memory
// and presents each fetched word with its address to the instruction register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          CLK,
  input  logic          RES,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  // Next-state and next-output decode; a jump overrides every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_req_d     = mem_req_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (bus.JMP) begin
      pc_d          = bus.JMP_ADDR;
      instr_valid_d = 1'b0;
      state_d       = ST_FETCH;
      mem_req_d     = 1'b1;
    end else begin
      case (state_q)
        ST_START: begin
          state_d   = ST_FETCH;
          mem_req_d = 1'b1;
        end
        ST_FETCH: begin
          if (bus.MEM_ACK) begin
            instr_d       = bus.MEM_DATA;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 16'd1;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
            mem_req_d     = 1'b0;
          end else begin
            state_d   = ST_FETCH;
            mem_req_d = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!bus.STALL) begin
            instr_valid_d = 1'b0;
            state_d       = ST_FETCH;
            mem_req_d     = 1'b1;
          end else begin
            state_d   = ST_HOLD;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d       = ST_START;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q       <= ST_START;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.MEM_REQ     = mem_req_q;
  assign bus.MEM_ADDR    = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_PC    = instr_pc_q;
  assign bus.INSTR_VALID = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts each delivered
// instruction and the per-cycle handshake outputs; a monitor checks deliveries.
module tb_fetch_unit;
  logic clk;
  logic res;

  fetch_unit_if bus_if ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Expected deliveries: {address, word}
  logic [31:0] sb_q[$];

  // Reference model: what the fetch unit is doing, in abstract terms
  logic [15:0] m_pc;
  logic        m_req;      // a memory request is outstanding
  logic        m_valid;    // an unconsumed instruction is held
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  int          m_delivered;
  int          seen_delivered;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_instr = 16'h0000;
    m_ipc   = 16'h0000;
  endtask

  // Apply the effect of the coming rising edge to the model.
  task automatic model_edge(input logic ack, input logic [15:0] data, input logic stall,
                            input logic jmp, input logic [15:0] jaddr);
    if (jmp) begin
      m_pc    = jaddr;
      m_valid = 1'b0;
      m_req   = 1'b1;
    end else if (m_req) begin
      if (ack) begin
        m_instr = data;
        m_ipc   = m_pc;
        sb_q.push_back({m_pc, data});
        m_delivered++;
        m_pc    = m_pc + 16'd1;
        m_valid = 1'b1;
        m_req   = 1'b0;
      end
    end else if (m_valid) begin
      if (!stall) begin
        m_valid = 1'b0;
        m_req   = 1'b1;
      end
    end else begin
      m_req = 1'b1;   // first request after reset
    end
  endtask

  task automatic check_outputs();
    chk("mem_req",     {15'd0, bus_if.MEM_REQ},     {15'd0, m_req});
    chk("mem_addr",    bus_if.MEM_ADDR,             m_pc);
    chk("instr_valid", {15'd0, bus_if.INSTR_VALID}, {15'd0, m_valid});
    chk("instr",       bus_if.INSTR,                m_instr);
    chk("instr_pc",    bus_if.INSTR_PC,             m_ipc);
  endtask

  // Called at a falling edge: check, drive, predict, advance one cycle.
  task automatic step(input logic ack, input logic [15:0] data, input logic stall,
                      input logic jmp, input logic [15:0] jaddr);
    check_outputs();
    bus_if.MEM_ACK  = ack;
    bus_if.MEM_DATA = data;
    bus_if.STALL    = stall;
    bus_if.JMP      = jmp;
    bus_if.JMP_ADDR = jaddr;
    model_edge(ack, data, stall, jmp, jaddr);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    check_outputs();
    bus_if.MEM_ACK = 1'b0;
    bus_if.STALL   = 1'b0;
    bus_if.JMP     = 1'b0;
    model_edge(1'b0, bus_if.MEM_DATA, 1'b0, 1'b0, bus_if.JMP_ADDR);
    @(posedge clk);
    #2;
    chk("pre_rst_req",  {15'd0, bus_if.MEM_REQ}, {15'd0, m_req});
    chk("pre_rst_addr", bus_if.MEM_ADDR, m_pc);
    res = 1'b1;
    #1;
    model_reset();
    chk("rst_mem_req",     {15'd0, bus_if.MEM_REQ},     16'h0000);
    chk("rst_instr_valid", {15'd0, bus_if.INSTR_VALID}, 16'h0000);
    chk("rst_mem_addr",    bus_if.MEM_ADDR,             16'h0000);
    #1;
    res = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every new delivery is compared against the scoreboard head.
  initial begin
    logic        prev_valid;
    logic [31:0] exp;
    prev_valid     = 1'b0;
    seen_delivered = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!res && bus_if.INSTR_VALID && !prev_valid) begin
        seen_delivered++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%h/%h expected=none", bus_if.INSTR_PC, bus_if.INSTR);
        end else begin
          exp = sb_q.pop_front();
          chk("sb_instr_pc", bus_if.INSTR_PC, exp[31:16]);
          chk("sb_instr",    bus_if.INSTR,    exp[15:0]);
        end
      end
      prev_valid = res ? 1'b0 : bus_if.INSTR_VALID;
    end
  end

  initial begin
    logic [15:0] ja;
    m_delivered     = 0;
    res             = 1'b1;
    bus_if.MEM_ACK  = 1'b0;
    bus_if.MEM_DATA = 16'h0000;
    bus_if.STALL    = 1'b0;
    bus_if.JMP      = 1'b0;
    bus_if.JMP_ADDR = 16'h0000;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    res = 1'b0;

    // Zero-wait streaming from reset
    for (int i = 0; i < 8; i++) step(1'b1, m_pc ^ 16'hA5A5, 1'b0, 1'b0, 16'h0000);

    // Wait states at 0000, then ack with BEEF
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);

    // Stall in HOLD for 5 cycles, ack noise ignored
    for (int i = 0; i < 5; i++) step(i[0], 16'h5555, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Jump/ack collision
    step(1'b1, 16'h1111, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);

    // Jump while stalled flushes
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000);

    // Wrap at FFFF
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 16'hCAFE, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 16'hF00D, 1'b0, 1'b0, 16'h0000);

    // Async reset mid-FETCH at 0042, then restart from RESET_PC
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    async_reset_pulse();
    for (int i = 0; i < 4; i++) step(1'b1, m_pc ^ 16'hA5A5, 1'b0, 1'b0, 16'h0000);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ja = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(($urandom_range(0, 2) != 0), 16'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ja);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

    chk("sb_drain",     16'(sb_q.size()),     16'h0000);
    chk("sb_delivered", 16'(seen_delivered),  16'(m_delivered));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
